// File: rtl/bsc_pkg.sv
// Shared types and helpers for the bit stream collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bsc_pkg;

  // Two-state collector FSM encoding.
  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } bsc_state_t;

  // Output buffer depth. The pointer logic in bsc_fifo2 assumes exactly two entries.
  localparam int BSC_FIFO_DEPTH = 2;

  // Saturating increment: holds at max_val instead of wrapping (counters up to 32 bits).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/bsc_fifo2.sv
// Two-entry register FIFO holding completed words for the parallel consumer.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module bsc_fifo2
  import bsc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [BSC_FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'(BSC_FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the incoming word needs.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < BSC_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/bit_stream_collector.sv
// Hunts for a sync pattern on a serial line, deserializes the next WIDTH bits MSB-first, buffers words.
// Latency: word valid one cycle after the edge that samples its last data bit (FIFO empty).
// Backpressure: valid/ready on the word side; a word completing into a full FIFO without a pop is dropped and counted.
module bit_stream_collector
  import bsc_pkg::*;
#(
  parameter int                  WIDTH        = 8,
  parameter int                  SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1011,
  parameter int                  CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             sample_en,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             hunting
);

  localparam int               CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bsc_state_t          state;
  logic [SYNC_LEN-1:0] history;
  logic [CW-1:0]       bit_cnt;
  logic [WIDTH-1:0]    shift;

  logic [SYNC_LEN:0]   hist_ext;
  logic [SYNC_LEN-1:0] hist_next;
  logic [WIDTH-1:0]    shift_next;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                accept;
  logic                drop;

  // Widening by one bit before truncating keeps this legal for a 1-bit sync pattern.
  assign hist_ext   = {history, din};
  assign hist_next  = hist_ext[SYNC_LEN-1:0];
  assign shift_next = {shift[WIDTH-2:0], din};

  assign push   = sample_en && (state == ST_COLLECT) && (bit_cnt == LAST);
  assign pop    = word_valid && word_ready;
  assign accept = push && (!fifo_full || pop);
  assign drop   = push && fifo_full && !pop;

  assign word_valid = !fifo_empty;
  assign hunting    = (state == ST_HUNT);

  // Sync hunt and word deserialization; everything holds while sample_en is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_HUNT;
      history <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (sample_en) begin
      if (state == ST_HUNT) begin
        history <= hist_next;
        if (hist_next == SYNC_PATTERN) begin
          state   <= ST_COLLECT;
          bit_cnt <= '0;
        end
      end else begin
        shift <= shift_next;
        if (bit_cnt == LAST) begin
          // Data bits are discarded from the hunt: restart from an empty history.
          state   <= ST_HUNT;
          history <= '0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  // Saturating statistics for accepted and dropped frames.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= '0;
      ovf_cnt   <= '0;
    end else begin
      if (accept) frame_cnt <= CNT_W'(sat_inc(32'(frame_cnt), 32'(CNT_MAX)));
      if (drop)   ovf_cnt   <= CNT_W'(sat_inc(32'(ovf_cnt), 32'(CNT_MAX)));
    end
  end

  bsc_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_next),
    .pop       (pop),
    .head      (word_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
